led_seq_ctrl: RTL and testbench

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

---
 rtl/led_seq_pkg.sv | 19 +
 rtl/led_tick_div.sv | 29 ++
 rtl/led_seq_ctrl.sv | 151 +++++++++++++++
 tb/tb_led_seq_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED sequencer: state encoding, ROM word fields and default timing.
package led_seq_pkg;

   localparam int unsigned TICK_DIV_DFLT = 3125000;

   localparam int PAT_MSB = 15;
   localparam int PAT_LSB = 8;
   localparam int DUR_MSB = 7;
   localparam int DUR_LSB = 0;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_FETCH = 3'd1;
   localparam state_t ST_LOAD  = 3'd2;
   localparam state_t ST_HOLD  = 3'd3;
   localparam state_t ST_DONE  = 3'd4;

endpackage

// File: rtl/led_tick_div.sv
// Duration prescaler: emits a one-cycle tick every TICK_DIV enabled cycles.
module led_tick_div
   import led_seq_pkg::*;
#(
   parameter int unsigned TICK_DIV = TICK_DIV_DFLT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;

   assign tick = en && (cnt_q == LAST);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer playing (pattern, duration) entries from a ROM over looped passes.
// Define LED_SEQ_STEP_EN to let a step pulse end the current entry while paused.
module led_seq_ctrl
   import led_seq_pkg::*;
#(
   parameter int unsigned TICK_DIV = TICK_DIV_DFLT,
   parameter int unsigned ADDR_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              pause,
   input  logic              step,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] last_addr,
   input  logic [7:0]        loop_cnt,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [15:0]       rom_data,
   output logic [7:0]        pattern,
   output logic              busy,
   output logic              done
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cur_q, cur_d, base_q, base_d, last_q, last_d;
   logic [7:0]        loops_q, loops_d, pass_q, pass_d;
   logic [7:0]        dur_q, dur_d, tcnt_q, tcnt_d, pattern_q, pattern_d;
   logic              done_q, done_d;

   logic       tick, step_hit, entry_end, skip, advance, more_passes;
   logic [7:0] rom_dur;

   assign rom_dur = rom_data[DUR_MSB:DUR_LSB];

`ifdef LED_SEQ_STEP_EN
   assign step_hit = (state_q == ST_HOLD) && pause && step;
`else
   logic unused_step;
   assign unused_step = step;
   assign step_hit    = 1'b0;
`endif

   led_tick_div #(
      .TICK_DIV(TICK_DIV)
   ) u_tick_div (
      .clk (clk),
      .rst (rst),
      .clr (state_q == ST_LOAD),
      .en  ((state_q == ST_HOLD) && !pause),
      .tick(tick)
   );

   // dur_q is never zero in HOLD, so dur_q-1 is the index of the final tick.
   assign entry_end   = (state_q == ST_HOLD) && ((tick && (tcnt_q == dur_q - 8'd1)) || step_hit);
   assign skip        = (state_q == ST_LOAD) && (rom_dur == 8'd0);
   assign advance     = entry_end || skip;
   assign more_passes = (loops_q == 8'd0) || (({1'b0, pass_q} + 9'd1) < {1'b0, loops_q});

   always_comb begin
      state_d   = state_q;
      cur_d     = cur_q;
      base_d    = base_q;
      last_d    = last_q;
      loops_d   = loops_q;
      pass_d    = pass_q;
      dur_d     = dur_q;
      tcnt_d    = tcnt_q;
      pattern_d = pattern_q;
      done_d    = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               base_d  = base_addr;
               last_d  = last_addr;
               loops_d = loop_cnt;
               cur_d   = base_addr;
               pass_d  = 8'd0;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: state_d = ST_LOAD;
         ST_LOAD: begin
            if (rom_dur != 8'd0) begin
               pattern_d = rom_data[PAT_MSB:PAT_LSB];
               dur_d     = rom_dur;
               tcnt_d    = 8'd0;
               state_d   = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (tick) tcnt_d = tcnt_q + 8'd1;
         end
         default: state_d = ST_IDLE;
      endcase

      if (advance) begin
         if (cur_q != last_q) begin
            cur_d   = cur_q + 1'b1;
            state_d = ST_FETCH;
         end else if (more_passes) begin
            pass_d  = pass_q + 8'd1;
            cur_d   = base_q;
            state_d = ST_FETCH;
         end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
         end
      end

      // stop overrides everything, including a coincident start
      if (stop) begin
         state_d   = ST_IDLE;
         pattern_d = 8'd0;
         done_d    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cur_q     <= '0;
         base_q    <= '0;
         last_q    <= '0;
         loops_q   <= 8'd0;
         pass_q    <= 8'd0;
         dur_q     <= 8'd0;
         tcnt_q    <= 8'd0;
         pattern_q <= 8'd0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_q     <= cur_d;
         base_q    <= base_d;
         last_q    <= last_d;
         loops_q   <= loops_d;
         pass_q    <= pass_d;
         dur_q     <= dur_d;
         tcnt_q    <= tcnt_d;
         pattern_q <= pattern_d;
         done_q    <= done_d;
      end
   end

   assign rom_addr = cur_q;
   assign pattern  = pattern_q;
   assign done     = done_q;
   assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed self-checking bench for led_seq_ctrl with TICK_DIV=4 and a synchronous-read ROM model.
module tb_led_seq_ctrl;

   localparam int unsigned TICK_DIV = 4;

   logic        clk = 1'b0;
   logic        rst, start, stop, pause, step;
   logic [7:0]  base_addr, last_addr, loop_cnt, rom_addr, pattern;
   logic [15:0] rom_data;
   logic        busy, done;
   logic [15:0] rom [256];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   always_ff @(posedge clk) rom_data <= rom[rom_addr];

   led_seq_ctrl #(
      .TICK_DIV(TICK_DIV),
      .ADDR_W  (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .stop     (stop),
      .pause    (pause),
      .step     (step),
      .base_addr(base_addr),
      .last_addr(last_addr),
      .loop_cnt (loop_cnt),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .pattern  (pattern),
      .busy     (busy),
      .done     (done)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_prog(input logic [7:0] b, input logic [7:0] l, input logic [7:0] lc);
      base_addr = b;
      last_addr = l;
      loop_cnt  = lc;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic wait_pat(input logic [7:0] p, output int n);
      n = 0;
      while (pattern !== p && n < 2000) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_addr_not(input logic [7:0] a, output int n);
      n = 0;
      while (rom_addr === a && n < 2000) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 4000) begin
         tick();
         n++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          n, t5, t6, nseq;
      bit          saw_ff;
      logic [63:0] seq;
      logic [7:0]  prev;

      rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; step = 1'b0;
      base_addr = '0; last_addr = '0; loop_cnt = '0;
      for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
      rom[2]   = 16'hA503;
      rom[3]   = 16'h3C01;
      rom[4]   = 16'h1101;
      rom[5]   = 16'hFF00;
      rom[6]   = 16'h2201;
      rom[10]  = 16'h5A02;
      rom[20]  = 16'h77FF;
      rom[21]  = 16'h8801;
      rom[30]  = 16'h9903;
      rom[254] = 16'h1001;
      rom[255] = 16'h2001;
      rom[0]   = 16'h3001;
      rom[1]   = 16'h4001;

      tick();
      tick();
      check("rst_addr", rom_addr, 8'h00);
      check("rst_pattern", pattern, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      rst = 1'b0;
      tick();

      // two-entry single pass
      run_prog(8'd2, 8'd3, 8'd1);
      check("t1_busy", busy, 1'b1);
      check("t1_addr", rom_addr, 8'd2);
      wait_pat(8'hA5, n);
      check("t1_load_lat", n, 2);
      wait_addr_not(8'd2, n);
      check("t1_a5_len", n, 12);
      check("t1_a5_pat", pattern, 8'hA5);
      wait_pat(8'h3C, n);
      check("t1_3c_lat", n, 2);
      wait_done(n);
      check("t1_3c_len", n, 4);
      check("t1_busy_done", busy, 1'b0);
      check("t1_pat_done", pattern, 8'h3C);
      tick();
      check("t1_done_pulse", done, 1'b0);
      check("t1_pat_hold", pattern, 8'h3C);

      // zero-duration entry is skipped
      run_prog(8'd4, 8'd6, 8'd1);
      saw_ff = 1'b0; t5 = -1; t6 = -1;
      for (int c = 0; c < 200 && done !== 1'b1; c++) begin
         if (pattern === 8'hFF) saw_ff = 1'b1;
         if (rom_addr === 8'd5 && t5 < 0) t5 = c;
         if (rom_addr === 8'd6 && t6 < 0) t6 = c;
         tick();
      end
      check("t2_skip_cycles", t6 - t5, 2);
      check("t2_no_ff", saw_ff, 1'b0);
      check("t2_done", done, 1'b1);
      check("t2_pattern", pattern, 8'h22);

      // address wrap over two passes
      run_prog(8'hFE, 8'h01, 8'd2);
      seq  = {56'd0, rom_addr};
      nseq = 1;
      prev = rom_addr;
      for (int c = 0; c < 400 && done !== 1'b1; c++) begin
         tick();
         if (rom_addr !== prev) begin
            seq  = {seq[55:0], rom_addr};
            nseq++;
            prev = rom_addr;
         end
      end
      check("t3_addr_seq", seq, 64'hFEFF_0001_FEFF_0001);
      check("t3_nseq", nseq, 8);
      check("t3_done", done, 1'b1);

      // pause stretches the entry, then stop beats start
      run_prog(8'd10, 8'd10, 8'd1);
      wait_pat(8'h5A, n);
      check("t4_load_lat", n, 2);
      tick(); tick(); tick();
      pause = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      pause = 1'b0;
      wait_done(n);
      check("t4_entry_len", 13 + n, 18);
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      check("t4_stop_busy", busy, 1'b0);
      check("t4_stop_pat", pattern, 8'h00);
      tick();
      check("t4_stop_idle", busy, 1'b0);

      // step while paused
      run_prog(8'd20, 8'd21, 8'd1);
      wait_pat(8'h77, n);
      check("t5_load_lat", n, 2);
      pause = 1'b1;
      tick(); tick();
      step = 1'b1;
      tick();
      step = 1'b0;
`ifdef LED_SEQ_STEP_EN
      check("t5_step_addr", rom_addr, 8'd21);
      check("t5_step_busy", busy, 1'b1);
      wait_pat(8'h88, n);
      check("t5_step_load", n, 2);
`else
      check("t5_step_addr", rom_addr, 8'd20);
      tick(); tick(); tick();
      check("t5_step_addr_late", rom_addr, 8'd20);
      check("t5_step_pat", pattern, 8'h77);
`endif
      pause = 1'b0;
      stop  = 1'b1;
      tick();
      stop  = 1'b0;
      check("t5_stop_pat", pattern, 8'h00);
      check("t5_stop_busy", busy, 1'b0);

      // reset mid-HOLD, then replay from base
      run_prog(8'd30, 8'd30, 8'd0);
      wait_pat(8'h99, n);
      check("t6_load_lat", n, 2);
      tick(); tick();
      rst = 1'b1;
      tick();
      check("t6_rst_addr", rom_addr, 8'h00);
      check("t6_rst_pat", pattern, 8'h00);
      check("t6_rst_busy", busy, 1'b0);
      check("t6_rst_done", done, 1'b0);
      rst = 1'b0;
      run_prog(8'd30, 8'd30, 8'd0);
      check("t6_replay_addr", rom_addr, 8'd30);
      check("t6_replay_busy", busy, 1'b1);
      wait_pat(8'h99, n);
      check("t6_replay_lat", n, 2);
      for (int i = 0; i < 14; i++) tick();
      check("t6_loop_busy", busy, 1'b1);
      stop = 1'b1;
      tick();
      stop = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
